// File: rtl/pci_pkg.sv
// Shared PCI bus definitions: arbiter FSM encoding, active-low levels and bus-idle sampling.
package pci_pkg;

    typedef enum logic [1:0] {
        PARK  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    localparam logic ASSERTED_N   = 1'b0;
    localparam logic DEASSERTED_N = 1'b1;

    // Only a clean 0 counts as asserted; 1, z and x all read as released.
    function automatic logic is_asserted(input logic sig_n);
        return (sig_n === ASSERTED_N);
    endfunction

    function automatic logic bus_idle(input logic frame, input logic irdy);
        return !is_asserted(frame) && !is_asserted(irdy);
    endfunction

endpackage

// File: rtl/pci_bus_arbiter_rr_picker.sv
// Combinational round-robin selector: first active request after `last`, wrapping modulo N.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    int idx;

    always_comb begin
        winner = last;
        any    = 1'b0;
        idx    = 0;
        // Offset 1..N so that `last` itself is considered only after every other master.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!any && req[idx]) begin
                winner = IDX_W'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central round-robin bus arbiter with grant timeout and early grant removal in BUSY.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_MASTERS-1:0]         req_n,
    input  logic                         frame,
    input  logic                         irdy,
    output logic [N_MASTERS-1:0]         gnt_n,
    output logic [$clog2(N_MASTERS)-1:0] owner,
    output logic                         owner_valid,
    output logic                         bus_busy,
    output logic                         timeout
);

    localparam int OWN_W = $clog2(N_MASTERS);
    localparam int CNT_W = $clog2(GNT_TIMEOUT + 1);
    localparam logic [N_MASTERS-1:0] ALL_OFF = '1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(GNT_TIMEOUT - 1);

    arb_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic [OWN_W-1:0]     last;
    logic [OWN_W-1:0]     winner;
    logic                 any_req;
    logic                 idle;
    logic                 frame_low;
    logic                 others_req;
    logic [N_MASTERS-1:0] req;

    assign req        = ~req_n;
    assign idle       = bus_idle(frame, irdy);
    assign frame_low  = is_asserted(frame);
    assign others_req = |(req & ~(N_MASTERS'(1) << owner));

    rr_picker #(
        .N     (N_MASTERS),
        .IDX_W (OWN_W)
    ) u_picker (
        .req    (req),
        .last   (last),
        .winner (winner),
        .any    (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PARK;
            cnt         <= '0;
            last        <= OWN_W'(N_MASTERS - 1);
            gnt_n       <= ALL_OFF;
            owner       <= '0;
            owner_valid <= 1'b0;
            bus_busy    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            bus_busy <= !idle;
            timeout  <= 1'b0;
            case (state)
                PARK: begin
                    // A busy bus here is a foreign or unfinished transaction: never grant into it.
                    if (any_req && idle) begin
                        gnt_n       <= ~(N_MASTERS'(1) << winner);
                        owner       <= winner;
                        last        <= winner;
                        owner_valid <= 1'b1;
                        cnt         <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    cnt <= cnt + 1'b1;
                    if (frame_low) begin
                        cnt   <= '0;
                        state <= BUSY;
                    end else if (req_n[owner] != ASSERTED_N) begin
                        gnt_n       <= ALL_OFF;
                        owner_valid <= 1'b0;
                        state       <= TURN;
                    end else if (cnt == CNT_LAST) begin
                        gnt_n       <= ALL_OFF;
                        owner_valid <= 1'b0;
                        timeout     <= 1'b1;
                        state       <= TURN;
                    end
                end
                BUSY: begin
                    if (idle) begin
                        gnt_n       <= ALL_OFF;
                        owner_valid <= 1'b0;
                        state       <= TURN;
                    end else if (others_req) begin
                        // Early removal: owner finishes its current transaction without the grant.
                        gnt_n <= ALL_OFF;
                    end
                end
                TURN: begin
                    state <= PARK;
                end
                default: begin
                    gnt_n       <= ALL_OFF;
                    owner_valid <= 1'b0;
                    state       <= PARK;
                end
            endcase
        end
    end

endmodule
